// File: rtl/sram_avalon_responder_if.sv
// Avalon-MM s1-style command/response bundle between the bus master and the SRAM responder.
interface sram_avalon_responder_if;
    logic [22:0] avs_address;
    logic [3:0]  avs_byteenable_n;
    logic        avs_chipselect;
    logic [31:0] avs_writedata;
    logic        avs_read_n;
    logic        avs_write_n;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;

    modport slave (
        input  avs_address, avs_byteenable_n, avs_chipselect, avs_writedata,
        input  avs_read_n, avs_write_n,
        output avs_readdata, avs_readdatavalid, avs_waitrequest
    );

    modport master (
        output avs_address, avs_byteenable_n, avs_chipselect, avs_writedata,
        output avs_read_n, avs_write_n,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest
    );
endinterface

// File: rtl/sram_avalon_responder.sv
// Serves 32-bit Avalon words from a 16-bit asynchronous SRAM as two half-accesses (LO, then HI).
// Every SRAM pin and every Avalon response is a flop loaded from the next state.
module sram_avalon_responder #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    sram_avalon_responder_if.slave  avs,
    inout  wire  [15:0]             SRAM_DQ,
    output logic [19:0]             SRAM_ADDR,
    output logic                    SRAM_OE_N,
    output logic                    SRAM_WE_N,
    output logic                    SRAM_CE_N,
    output logic                    SRAM_UB_N,
    output logic                    SRAM_LB_N
);

    typedef enum logic [2:0] {
        StIdle, StRdLo, StRdHi, StWrLoSu, StWrLoSt, StWrHiSu, StWrHiSt, StAck
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [18:0] addr_q;
    logic [3:0]  be_n_q;
    logic [31:0] wdata_q;
    logic        is_read_q;
    logic [31:0] readdata_q;
    logic        rdv_q, wait_q;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic        oe_n_q, oe_n_d, we_n_q, we_n_d, ce_n_q, ce_n_d;
    logic        ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [15:0] dq_out_q, dq_out_d;

    logic        req, wr_req, last_cyc;
    logic [18:0] cur_addr;
    logic [3:0]  cur_be_n;
    logic [31:0] cur_wdata;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^avs.avs_address[22:19];

    assign req      = avs.avs_chipselect & (~avs.avs_read_n | ~avs.avs_write_n);
    assign wr_req   = avs.avs_chipselect & ~avs.avs_write_n;
    assign last_cyc = (cnt_q == 3'(WAIT_CYCLES - 1));

    // In IDLE the outputs for the first access state come straight from the bus.
    assign cur_addr  = (state_q == StIdle) ? avs.avs_address[18:0] : addr_q;
    assign cur_be_n  = (state_q == StIdle) ? avs.avs_byteenable_n  : be_n_q;
    assign cur_wdata = (state_q == StIdle) ? avs.avs_writedata     : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (wr_req) begin
                        if (avs.avs_byteenable_n == 4'hF)           state_d = StAck;
                        else if (avs.avs_byteenable_n[1:0] == 2'b11) state_d = StWrHiSu;
                        else                                         state_d = StWrLoSu;
                    end else begin
                        state_d = StRdLo;
                    end
                end
            end
            StRdLo:   if (last_cyc) state_d = StRdHi; else cnt_d = cnt_q + 3'd1;
            StRdHi:   if (last_cyc) state_d = StAck;  else cnt_d = cnt_q + 3'd1;
            StWrLoSu: state_d = StWrLoSt;
            StWrLoSt: begin
                if (last_cyc) state_d = (be_n_q[3:2] == 2'b11) ? StAck : StWrHiSu;
                else          cnt_d   = cnt_q + 3'd1;
            end
            StWrHiSu: state_d = StWrHiSt;
            StWrHiSt: if (last_cyc) state_d = StAck; else cnt_d = cnt_q + 3'd1;
            StAck:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        ce_n_d      = (state_d == StIdle);
        case (state_d)
            StRdLo, StRdHi: begin
                oe_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                lb_n_d      = 1'b0;
                sram_addr_d = {cur_addr, state_d == StRdHi};
            end
            StWrLoSu, StWrLoSt: begin
                we_n_d      = (state_d != StWrLoSt);
                lb_n_d      = cur_be_n[0];
                ub_n_d      = cur_be_n[1];
                sram_addr_d = {cur_addr, 1'b0};
                dq_oe_d     = 1'b1;
                dq_out_d    = cur_wdata[15:0];
            end
            StWrHiSu, StWrHiSt: begin
                we_n_d      = (state_d != StWrHiSt);
                lb_n_d      = cur_be_n[2];
                ub_n_d      = cur_be_n[3];
                sram_addr_d = {cur_addr, 1'b1};
                dq_oe_d     = 1'b1;
                dq_out_d    = cur_wdata[31:16];
            end
            // Keep driving DQ for the cycle in which WE_N rises after a strobe.
            StAck:   dq_oe_d = (state_q == StWrLoSt) || (state_q == StWrHiSt);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            be_n_q      <= 4'hF;
            wdata_q     <= '0;
            is_read_q   <= 1'b0;
            readdata_q  <= '0;
            rdv_q       <= 1'b0;
            wait_q      <= 1'b1;
            sram_addr_q <= '0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdv_q       <= (state_q == StAck) && is_read_q;
            wait_q      <= (state_d != StAck);
            sram_addr_q <= sram_addr_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ce_n_q      <= ce_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
            if (state_q == StIdle && req) begin
                addr_q    <= avs.avs_address[18:0];
                be_n_q    <= avs.avs_byteenable_n;
                wdata_q   <= avs.avs_writedata;
                is_read_q <= ~wr_req;
            end
            if (state_q == StRdLo && last_cyc) readdata_q[15:0]  <= SRAM_DQ;
            if (state_q == StRdHi && last_cyc) readdata_q[31:16] <= SRAM_DQ;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;

    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = rdv_q;
    assign avs.avs_waitrequest   = wait_q;

endmodule

// File: tb/tb_sram_avalon_responder.sv
// Directed bench: two responders (WAIT_CYCLES 1 and 3) on behavioural SRAM models.
module tb_sram_avalon_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [22:0] m_addr;
    logic [3:0]  m_be_n;
    logic [31:0] m_wd;
    logic        m_rd_n, m_wr_n;
    logic [1:0]  m_cs;

    sram_avalon_responder_if bus0 ();
    sram_avalon_responder_if bus1 ();

    assign bus0.avs_address      = m_addr;
    assign bus0.avs_byteenable_n = m_be_n;
    assign bus0.avs_writedata    = m_wd;
    assign bus0.avs_read_n       = m_rd_n;
    assign bus0.avs_write_n      = m_wr_n;
    assign bus0.avs_chipselect   = m_cs[0];
    assign bus1.avs_address      = m_addr;
    assign bus1.avs_byteenable_n = m_be_n;
    assign bus1.avs_writedata    = m_wd;
    assign bus1.avs_read_n       = m_rd_n;
    assign bus1.avs_write_n      = m_wr_n;
    assign bus1.avs_chipselect   = m_cs[1];

    wire  [15:0] dq0, dq1;
    logic [19:0] addr0, addr1;
    logic        oe0, we0, ce0, ub0, lb0, oe1, we1, ce1, ub1, lb1;

    sram_avalon_responder #(.WAIT_CYCLES(1)) dut0 (
        .i_clk(clk), .i_rst(rst_n), .avs(bus0), .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_OE_N(oe0), .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_avalon_responder #(.WAIT_CYCLES(3)) dut1 (
        .i_clk(clk), .i_rst(rst_n), .avs(bus1), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_OE_N(oe1), .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    logic [1:0]  wreq, rdv;
    logic [31:0] rdata0, rdata1;
    assign wreq   = {bus1.avs_waitrequest, bus0.avs_waitrequest};
    assign rdv    = {bus1.avs_readdatavalid, bus0.avs_readdatavalid};
    assign rdata0 = bus0.avs_readdata;
    assign rdata1 = bus1.avs_readdata;

    // SRAM models: write while WE_N is low at a clock edge, drive DQ while OE_N is low.
    logic [15:0] mem0 [0:1023];
    logic [15:0] mem1 [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [15:0] pre_val = '0;

    assign dq0 = (!ce0 && !oe0 && we0) ? mem0[addr0[9:0]] : 16'hzzzz;
    assign dq1 = (!ce1 && !oe1 && we1) ? mem1[addr1[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (pre_en) begin
            mem0[pre_idx] <= pre_val;
        end else if (!ce0 && !we0) begin
            if (!lb0) mem0[addr0[9:0]][7:0]  <= dq0[7:0];
            if (!ub0) mem0[addr0[9:0]][15:8] <= dq0[15:8];
        end
    end

    always @(posedge clk) begin
        if (!ce1 && !we1) begin
            if (!lb1) mem1[addr1[9:0]][7:0]  <= dq1[7:0];
            if (!ub1) mem1[addr1[9:0]][15:8] <= dq1[15:8];
        end
    end

    // Strobe counters and a sticky count of WE_N falling together with an ADDR/DQ change.
    int          we_low0 = 0, we_low1 = 0, viol0 = 0, viol1 = 0;
    logic        last_lb0 = 1'b1, last_ub0 = 1'b1;
    logic        prev_we0 = 1'b1, prev_we1 = 1'b1;
    logic [19:0] prev_addr0 = '0, prev_addr1 = '0;
    logic [15:0] prev_dq0 = '0, prev_dq1 = '0;

    always @(negedge clk) begin
        if (!we0) begin
            we_low0  <= we_low0 + 1;
            last_lb0 <= lb0;
            last_ub0 <= ub0;
        end
        if ((!we0 && addr0[19:10] != 10'd0) ||
            (prev_we0 && !we0 && (addr0 != prev_addr0 || dq0 != prev_dq0)))
            viol0 <= viol0 + 1;
        if (!we1) we_low1 <= we_low1 + 1;
        if (prev_we1 && !we1 && (addr1 != prev_addr1 || dq1 != prev_dq1))
            viol1 <= viol1 + 1;
        prev_we0   <= we0;
        prev_addr0 <= addr0;
        prev_dq0   <= dq0;
        prev_we1   <= we1;
        prev_addr1 <= addr1;
        prev_dq1   <= dq1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic preset(input int idx, input logic [15:0] v);
        @(negedge clk);
        pre_idx = idx[9:0];
        pre_val = v;
        pre_en  = 1'b1;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Cycle 0 is the cycle in which the request is first presented.
    task automatic run_cmd(input int w, input bit wr, input bit rd, input logic [22:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           output int ack_c, output int rdv_c, output logic [31:0] rd_d);
        ack_c = -1;
        rdv_c = -1;
        rd_d  = '0;
        @(negedge clk);
        m_addr = a;
        m_be_n = be;
        m_wd   = wd;
        m_wr_n = !wr;
        m_rd_n = !rd;
        m_cs   = (w == 0) ? 2'b01 : 2'b10;
        for (int c = 1; c <= 40 && ack_c < 0; c++) begin
            @(negedge clk);
            if (!wreq[w]) ack_c = c;
        end
        m_cs   = 2'b00;
        m_rd_n = 1'b1;
        m_wr_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (rdv[w] && rdv_c < 0) begin
                rdv_c = ack_c + c;
                rd_d  = (w == 0) ? rdata0 : rdata1;
            end
        end
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [22:0] addr;
        logic [3:0]  be_n;
        logic [31:0] wd;
        int          ack;
        int          rdv;
        logic [31:0] rdat;
        int          strobes;
        int          idx;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t vt [7];

    initial begin
        int          ack_c, rdv_c, s0, found, seen;
        logic [31:0] rd_d;

        vt[0] = '{1'b1, 1'b0, 23'd5,       4'h0, 32'hDEAD_BEEF, 5, -1, 32'h0,         2, 10,
                  16'hBEEF, 16'hDEAD};
        vt[1] = '{1'b0, 1'b1, 23'd5,       4'h0, 32'h0,         3,  4, 32'hDEAD_BEEF, 0, 0,
                  16'h0, 16'h0};
        vt[2] = '{1'b1, 1'b1, 23'h080003,  4'h0, 32'h1234_5678, 5, -1, 32'h0,         2, 6,
                  16'h5678, 16'h1234};
        vt[3] = '{1'b0, 1'b1, 23'h000003,  4'h0, 32'h0,         3,  4, 32'h1234_5678, 0, 0,
                  16'h0, 16'h0};
        vt[4] = '{1'b1, 1'b0, 23'd4,       4'h0, 32'hCAFE_F00D, 5, -1, 32'h0,         2, 8,
                  16'hF00D, 16'hCAFE};
        vt[5] = '{1'b0, 1'b1, 23'd4,       4'h0, 32'h0,         3,  4, 32'hCAFE_F00D, 0, 0,
                  16'h0, 16'h0};
        vt[6] = '{1'b0, 1'b1, 23'h080005,  4'h0, 32'h0,         3,  4, 32'hDEAD_BEEF, 0, 0,
                  16'h0, 16'h0};

        // Reset held while a read is requested.
        rst_n  = 1'b0;
        m_addr = 23'd5;
        m_be_n = 4'h0;
        m_wd   = '0;
        m_rd_n = 1'b0;
        m_wr_n = 1'b1;
        m_cs   = 2'b11;
        repeat (3) @(negedge clk);
        check32("rst_waitrequest", 32'(wreq), 32'h3);
        check32("rst_readdatavalid", 32'(rdv), 32'h0);
        check32("rst_readdata", rdata0, 32'h0);
        check32("rst_ce_n", 32'({ce1, ce0}), 32'h3);
        check32("rst_oe_we_n", 32'({oe0, we0}), 32'h3);
        check32("rst_ub_lb_n", 32'({ub0, lb0}), 32'h3);
        check32("rst_addr", 32'(addr0), 32'h0);
        m_cs   = 2'b00;
        m_rd_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            s0 = we_low0;
            run_cmd(0, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].be_n, vt[i].wd, ack_c, rdv_c, rd_d);
            check32($sformatf("vec%0d_ack_cycle", i), 32'(ack_c), 32'(vt[i].ack));
            check32($sformatf("vec%0d_rdv_cycle", i), 32'(rdv_c), 32'(vt[i].rdv));
            check32($sformatf("vec%0d_strobes", i), 32'(we_low0 - s0), 32'(vt[i].strobes));
            if (vt[i].wr) begin
                check32($sformatf("vec%0d_mem_lo", i), 32'(mem0[vt[i].idx]), 32'(vt[i].lo));
                check32($sformatf("vec%0d_mem_hi", i), 32'(mem0[vt[i].idx + 1]), 32'(vt[i].hi));
            end else begin
                check32($sformatf("vec%0d_readdata", i), rd_d, vt[i].rdat);
            end
        end

        // HI-only partial write.
        preset(10, 16'h1111);
        preset(11, 16'h1111);
        s0 = we_low0;
        run_cmd(0, 1'b1, 1'b0, 23'd5, 4'b0011, 32'hAABB_CCDD, ack_c, rdv_c, rd_d);
        check32("hi_only_ack_cycle", 32'(ack_c), 32'd3);
        check32("hi_only_strobes", 32'(we_low0 - s0), 32'd1);
        check32("hi_only_ub_lb_n", 32'({last_ub0, last_lb0}), 32'h0);
        check32("hi_only_mem_hi", 32'(mem0[11]), 32'h0000_AABB);
        check32("hi_only_mem_lo", 32'(mem0[10]), 32'h0000_1111);

        // Single low byte.
        preset(16, 16'h2222);
        preset(17, 16'h3333);
        s0 = we_low0;
        run_cmd(0, 1'b1, 1'b0, 23'd8, 4'b1110, 32'h4444_5555, ack_c, rdv_c, rd_d);
        check32("byte_ack_cycle", 32'(ack_c), 32'd3);
        check32("byte_strobes", 32'(we_low0 - s0), 32'd1);
        check32("byte_ub_lb_n", 32'({last_ub0, last_lb0}), 32'h2);
        check32("byte_mem_lo", 32'(mem0[16]), 32'h0000_2255);
        check32("byte_mem_hi", 32'(mem0[17]), 32'h0000_3333);

        // No byte enabled: immediate ack, SRAM untouched.
        s0 = we_low0;
        run_cmd(0, 1'b1, 1'b0, 23'd8, 4'hF, 32'hFFFF_FFFF, ack_c, rdv_c, rd_d);
        check32("noop_ack_cycle", 32'(ack_c), 32'd1);
        check32("noop_strobes", 32'(we_low0 - s0), 32'd0);
        check32("noop_rdv_cycle", 32'(rdv_c), 32'hFFFF_FFFF);
        check32("noop_mem_lo", 32'(mem0[16]), 32'h0000_2255);

        // Reset during the HI strobe abandons the write.
        preset(19, 16'h7777);
        @(negedge clk);
        m_addr = 23'd9;
        m_be_n = 4'h0;
        m_wd   = 32'h9999_8888;
        m_wr_n = 1'b0;
        m_rd_n = 1'b1;
        m_cs   = 2'b01;
        found  = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            if (!we0 && addr0[0]) found = 1;
        end
        check32("abort_reached_hi_strobe", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check32("abort_waitrequest", 32'(wreq[0]), 32'd1);
        check32("abort_ce_oe_we_n", 32'({ce0, oe0, we0}), 32'h7);
        check32("abort_ub_lb_n", 32'({ub0, lb0}), 32'h3);
        check32("abort_addr", 32'(addr0), 32'h0);
        m_cs   = 2'b00;
        m_wr_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (3) begin
            @(negedge clk);
            if (!wreq[0] || rdv[0]) seen++;
        end
        check32("abort_no_ack", 32'(seen), 32'd0);
        check32("abort_mem_lo", 32'(mem0[18]), 32'h0000_8888);
        check32("abort_mem_hi", 32'(mem0[19]), 32'h0000_7777);
        run_cmd(0, 1'b0, 1'b1, 23'd3, 4'h0, 32'h0, ack_c, rdv_c, rd_d);
        check32("post_abort_ack_cycle", 32'(ack_c), 32'd3);
        check32("post_abort_rdv_cycle", 32'(rdv_c), 32'd4);
        check32("post_abort_readdata", rd_d, 32'h1234_5678);

        // Three strobe cycles per half-access.
        s0 = we_low1;
        run_cmd(1, 1'b1, 1'b0, 23'd5, 4'h0, 32'hDEAD_BEEF, ack_c, rdv_c, rd_d);
        check32("wc3_write_ack_cycle", 32'(ack_c), 32'd9);
        check32("wc3_strobes", 32'(we_low1 - s0), 32'd6);
        check32("wc3_mem_lo", 32'(mem1[10]), 32'h0000_BEEF);
        check32("wc3_mem_hi", 32'(mem1[11]), 32'h0000_DEAD);
        run_cmd(1, 1'b0, 1'b1, 23'd5, 4'h0, 32'h0, ack_c, rdv_c, rd_d);
        check32("wc3_read_ack_cycle", 32'(ack_c), 32'd7);
        check32("wc3_read_rdv_cycle", 32'(rdv_c), 32'd8);
        check32("wc3_readdata", rd_d, 32'hDEAD_BEEF);

        check32("we_fall_hazards_dut0", 32'(viol0), 32'd0);
        check32("we_fall_hazards_dut1", 32'(viol1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected end of test");
        $fatal(1, "simulation time limit reached");
    end

endmodule
